// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: drives the shared 16-bit ALU through a
// fetch / multiply / accumulate loop to produce one dot-product element,
// sum over k of A[a_base+k] * B[b_base+k*b_stride].
//
// Handshake: start is a single-cycle request that is accepted only while
// the sequencer is IDLE (busy=0); any start seen while busy is dropped and
// inputs are not re-latched. Completion is signalled by a single-cycle done
// pulse; result takes the accumulated sum on the edge that ends the done
// cycle and holds it until the next accepted start completes.
module dot_product_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] b_stride,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       alu_in1,
    output logic [15:0]       alu_in2,
    output logic [2:0]        alu_op,
    input  logic [15:0]       alu_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_PASS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_LOAD_A  = 3'd2,
        S_LOAD_B  = 3'd3,
        S_MUL     = 3'd4,
        S_ACC     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly
    state_t            state;
    logic [ADDR_W-1:0] a_ptr;
    logic [ADDR_W-1:0] b_ptr;
    logic [ADDR_W-1:0] stride_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt;
    logic [15:0]       a_reg;
    logic [15:0]       b_reg;
    logic [15:0]       prod;
    logic [15:0]       acc;
    logic              last_elem;

    assign last_elem = (cnt == len_reg - LEN_W'(1));

    // Sequencer FSM: latches the job on start and walks the five-cycle loop per element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_ptr      <= '0;
            b_ptr      <= '0;
            stride_reg <= '0;
            len_reg    <= '0;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            prod       <= '0;
            acc        <= '0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_reg    <= len;
                        a_ptr      <= a_base;
                        b_ptr      <= b_base;
                        stride_reg <= b_stride;
                        cnt        <= '0;
                        acc        <= '0;
                        state      <= (len == '0) ? S_DONE : S_FETCH_A;
                    end
                end
                S_FETCH_A: state <= S_LOAD_A;
                S_LOAD_A: begin
                    a_reg <= mem_rdata;
                    state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    b_reg <= mem_rdata;
                    state <= S_MUL;
                end
                S_MUL: begin
                    prod  <= alu_out;
                    state <= S_ACC;
                end
                S_ACC: begin
                    acc   <= alu_out;
                    a_ptr <= a_ptr + ADDR_W'(1);
                    b_ptr <= b_ptr + stride_reg;
                    cnt   <= cnt + LEN_W'(1);
                    state <= last_elem ? S_DONE : S_FETCH_A;
                end
                S_DONE: begin
                    result <= acc;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode: memory and ALU lines are driven only in the states that use them
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        alu_op    = OP_PASS;
        alu_in1   = '0;
        alu_in2   = '0;
        case (state)
            S_FETCH_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = a_ptr;
            end
            S_LOAD_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = b_ptr;
            end
            S_MUL: begin
                alu_op  = OP_MUL;
                alu_in1 = a_reg;
                alu_in2 = b_reg;
            end
            S_ACC: begin
                alu_op  = OP_ADD;
                alu_in1 = acc;
                alu_in2 = prod;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
